mux_4x1_rr_sched: RTL and testbench
===================================

Name: mux_4x1_rr_sched

Overview:
Round-robin scheduler that sits directly upstream of the 4:1 mux and generates its 2-bit select.
- Four requesters (channels a, b, c, d) present data with a valid/ready handshake.
- The block picks one requester fairly and registers the select and the selected data.
- It presents them downstream on a single valid/ready output.
- sel output wires straight to the mux select; out_data mirrors what the mux would emit for that sel.

Parameters:
- WIDTH, 4, data width of each channel and of out_data.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d.
- a  input  WIDTH  channel 0 data.
- b  input  WIDTH  channel 1 data.
- c  input  WIDTH  channel 2 data.
- d  input  WIDTH  channel 3 data.
- gnt  output  4  per-channel ready, one-hot or zero, combinational.
- sel  output  2  registered index of the channel held in the output register.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values (immediate on rst_n low, independent of clk):
  - sel=0, out_data=0, out_valid=0.
  - Internal priority pointer ptr=0.
  - gnt forced to 0 while rst_n=0.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition: load = (!out_valid || out_ready) && (req != 0).
- Arbitration (combinational):
  - Scan req starting at index ptr, then ptr+1, ptr+2, ptr+3, mod 4.
  - First set bit is the winner idx.
  - gnt[idx]=1 only when load=1; otherwise gnt=0.
- On a clock edge with load=1:
  - sel<=idx.
  - out_data<= the data of channel idx.
  - out_valid<=1.
  - ptr<=(idx+1) mod 4, wrapping from 3 to 0.
- A requester sees its transfer complete in the cycle where req[i]=1 and gnt[i]=1. It may drop or change its data from the next cycle.
- Edge with out_valid=1, out_ready=1, req=0: out_valid<=0. sel and out_data hold their last values.
- Edge with out_valid=1, out_ready=0: all outputs and ptr hold; gnt=0 (backpressure).
- Simultaneous drain and load (out_valid=1, out_ready=1, req!=0):
  - New word is loaded in the same edge; out_valid stays 1.
  - Zero-bubble throughput of 1 word/cycle.
- Latency: request accepted at edge N appears on out_data/sel/out_valid after edge N (1 cycle).
- ptr advances only on a load. Idle cycles and stalled cycles do not move it.
- Fairness: with all four req held high and out_ready=1, grants cycle 0,1,2,3,0,... and each channel waits at most 3 other grants.
- req may change at any time. Arbitration uses the current-cycle value; there is no request latching.
- Reset asserted mid-operation:
  - Any held word is discarded and ptr returns to 0.
  - After release, the first grant goes to the lowest-index active requester.
- Data width: out_data is exactly WIDTH bits; no arithmetic on data. sel is exactly 2 bits.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out_valid=1 -> out_valid, sel and out_data go to 0 before the next clk edge and gnt=0. After release with req=4'b1010 -> first gnt=4'b0010, sel=1.
- Single requester: req=4'b0100, c=4'hA, out_ready=1 -> gnt=4'b0100. Next cycle sel=2, out_data=4'hA, out_valid=1.
- Full rotation: req=4'b1111, a=1, b=2, c=3, d=4, out_ready=1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4 with out_valid=1 every cycle after the first.
- Backpressure: out_valid=1 holding sel=1, out_ready=0 for 3 cycles with req=4'b1111 -> gnt=0 and sel/out_data stable. Set out_ready=1 -> next grant is channel 2.
- Pointer wrap and skip: last grant was channel 3, then req=4'b0110 -> grant channel 1, then channel 2; ptr ends at 3.
- Drain without reload: out_valid=1, out_ready=1, req=0 -> out_valid=0 next cycle, sel and out_data unchanged. Idle 5 cycles with ptr unchanged, then req=4'b1111 -> grant resumes at the stored ptr.

Source files
------------

// File: rtl/mux_4x1_rr_sched_if.sv
// Bundle of the four requester channels, their grants and the single
// downstream valid/ready output of the round-robin mux scheduler.
interface mux_4x1_rr_sched_if #(
   parameter int WIDTH = 4
);
   logic [3:0]       req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   // Requesters plus downstream consumer side
   modport master (
      output req, a, b, c, d, out_ready,
      input  gnt, sel, out_data, out_valid
   );

   // Scheduler side
   modport slave (
      input  req, a, b, c, d, out_ready,
      output gnt, sel, out_data, out_valid
   );
endinterface

// File: rtl/mux_4x1_rr_sched.sv
// Round-robin scheduler feeding a 4:1 mux. Picks one of four requesters
// starting from a rotating priority pointer, registers the winning index
// (sel) and its data, and offers them downstream with valid/ready. A new
// word may be loaded on the same edge the old one drains, so throughput is
// one word per cycle.
module mux_4x1_rr_sched #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mux_4x1_rr_sched_if.slave   bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic [1:0]       idx;
   logic             any_req;
   logic             load;

   // State register: output-register occupancy, pointer, select and data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end

   // Find the first active requester scanning upward from ptr, wrapping at 3
   always_comb begin : arb
      logic [1:0] pos;
      pos     = 2'd0;
      idx     = ptr_q;
      any_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pos = ptr_q + 2'(k);
         if (!any_req && bus.req[pos]) begin
            idx     = pos;
            any_req = 1'b1;
         end
      end
   end

   // A word is taken when the output slot is free or draining this edge
   always_comb begin
      load = ((state_q == EMPTY) || bus.out_ready) && any_req;
   end

   // Next-state: fill on load, empty on a drain with nothing to replace it
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (load) state_d = FULL;
         FULL:  if (bus.out_ready && !load) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Datapath next values: capture the winner and move priority past it
   always_comb begin
      sel_d  = sel_q;
      data_d = data_q;
      ptr_d  = ptr_q;
      if (load) begin
         sel_d = idx;
         ptr_d = idx + 2'd1;
         case (idx)
            2'd0:    data_d = bus.a;
            2'd1:    data_d = bus.b;
            2'd2:    data_d = bus.c;
            default: data_d = bus.d;
         endcase
      end
   end

   // Outputs: one-hot grant only while loading and out of reset
   always_comb begin
      bus.gnt = 4'b0000;
      if (load && rst_n) begin
         bus.gnt[idx] = 1'b1;
      end
      bus.out_valid = (state_q == FULL);
      bus.sel       = sel_q;
      bus.out_data  = data_q;
   end

endmodule

// File: tb/tb_mux_4x1_rr_sched.sv
// Scoreboard bench for the round-robin mux scheduler. A behavioural model
// decides each cycle who should be granted and queues the expected word;
// an independent monitor pops and compares when the DUT presents a word.
module tb_mux_4x1_rr_sched;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic [1:0]       sel;
      logic [WIDTH-1:0] data;
   } word_t;

   logic clk;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   word_t expQ[$];

   // Model state: priority start and whether a word sits downstream
   int modelPtr  = 0;
   bit modelFull = 0;

   bit               slotFree = 1'b1;
   logic [1:0]       heldSel  = 2'd0;
   logic [WIDTH-1:0] heldData = '0;

   mux_4x1_rr_sched_if #(.WIDTH(WIDTH)) bus ();

   mux_4x1_rr_sched #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive at negedge, check grant against the model,
   // then queue whatever the model says gets loaded on the coming edge.
   task automatic applyStimulus(input logic [3:0] r,
                                input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                                input logic [WIDTH-1:0] dc, input logic [WIDTH-1:0] dd,
                                input logic rdy);
      logic [WIDTH-1:0] dat[4];
      int winner;
      bit canLoad;
      logic [3:0] expGnt;
      word_t w;
      @(negedge clk);
      rst_n         = 1'b1;
      bus.req       = r;
      bus.a         = da;
      bus.b         = db;
      bus.c         = dc;
      bus.d         = dd;
      bus.out_ready = rdy;
      dat[0] = da; dat[1] = db; dat[2] = dc; dat[3] = dd;
      winner = -1;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (modelPtr + k) % 4;
         if (winner < 0 && r[i]) winner = i;
      end
      canLoad = (!modelFull || rdy) && (winner >= 0);
      expGnt  = canLoad ? (4'b0001 << winner) : 4'b0000;
      #1;
      checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
      if (canLoad) begin
         w.sel  = 2'(winner);
         w.data = dat[winner];
         expQ.push_back(w);
         modelPtr  = (winner + 1) % 4;
         modelFull = 1'b1;
      end else if (modelFull && rdy) begin
         modelFull = 1'b0;
      end
   endtask

   // Assert reset part-way through a cycle and confirm it acts at once
   task automatic applyReset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
      checkOutput("rstSel",   32'(bus.sel),       32'd0);
      checkOutput("rstData",  32'(bus.out_data),  32'd0);
      checkOutput("rstGnt",   32'(bus.gnt),       32'd0);
      expQ.delete();
      modelPtr  = 0;
      modelFull = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   // Record whether the output slot can take a new word on the next edge
   always @(negedge clk) begin
      #2;
      slotFree = !bus.out_valid || bus.out_ready;
   end

   // Monitor: after each edge either a new word appears, the slot is empty
   // with old values held, or a stalled word is held unchanged
   always @(posedge clk) begin
      word_t e;
      #1;
      if (!rst_n) begin
         heldSel  = 2'd0;
         heldData = '0;
      end else if (slotFree) begin
         if (bus.out_valid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedWord: got sel=%0d data=%0h expected none at %0t",
                        bus.sel, bus.out_data, $time);
            end else begin
               e = expQ.pop_front();
               checkOutput("sel",     32'(bus.sel),      32'(e.sel));
               checkOutput("outData", 32'(bus.out_data), 32'(e.data));
            end
            heldSel  = bus.sel;
            heldData = bus.out_data;
         end else begin
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checks++;
               errors++;
               $display("[TB] FAIL missingWord: got out_valid=0 expected sel=%0d data=%0h at %0t",
                        e.sel, e.data, $time);
            end
            checkOutput("idleSel",  32'(bus.sel),      32'(heldSel));
            checkOutput("idleData", 32'(bus.out_data), 32'(heldData));
         end
      end else begin
         checkOutput("stallValid", 32'(bus.out_valid), 32'd1);
         checkOutput("stallSel",   32'(bus.sel),       32'(heldSel));
         checkOutput("stallData",  32'(bus.out_data),  32'(heldData));
      end
   end

   initial begin
      $display("[TB] starting mux_4x1_rr_sched bench");
      rst_n         = 1'b0;
      bus.req       = 4'b0000;
      bus.a         = '0;
      bus.b         = '0;
      bus.c         = '0;
      bus.d         = '0;
      bus.out_ready = 1'b0;
      #2;
      checkOutput("initValid", 32'(bus.out_valid), 32'd0);
      checkOutput("initGnt",   32'(bus.gnt),       32'd0);

      // Single requester on channel c
      applyStimulus(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1);
      // Hold the word downstream while requests keep coming
      applyStimulus(4'b1010, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
      applyStimulus(4'b1010, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0);

      // Reset with a word held, then first grant goes to channel 1
      applyReset();
      applyStimulus(4'b1010, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
      applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

      // Full rotation from a fresh pointer
      applyReset();
      for (int n = 0; n < 8; n++) begin
         applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
      end

      // Backpressure with channel 1 held
      applyStimulus(4'b0010, 4'h1, 4'h9, 4'h3, 4'h4, 1'b1);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
      end
      applyStimulus(4'b1111, 4'h1, 4'h2, 4'hC, 4'h4, 1'b1);

      // Pointer wrap and skip: grant 3, then 1 then 2
      applyStimulus(4'b1000, 4'h1, 4'h2, 4'h3, 4'hD, 1'b1);
      applyStimulus(4'b0110, 4'h1, 4'hB, 4'hE, 4'h4, 1'b1);
      applyStimulus(4'b0110, 4'h1, 4'hB, 4'hE, 4'h4, 1'b1);

      // Drain without reload, idle, then resume at the stored pointer
      for (int n = 0; n < 6; n++) begin
         applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      end
      applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
      applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);

      // Randomized traffic with occasional stalls and a mid-run reset
      for (int n = 0; n < 400; n++) begin
         logic [3:0] r;
         logic       rdy;
         r   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         rdy = ($urandom_range(0, 3) != 0);
         applyStimulus(r, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rdy);
         if (n == 200) applyReset();
      end

      // Let the last word out and make sure nothing was left unmatched
      applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      @(posedge clk);
      #2;
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
